// File: rtl/data_mem_access_ctrl.sv
// MEM-stage data memory access controller: issues SRAM-like bus transactions
// for loads/stores, stalls the MEM stage while busy, and loads WB-stage registers.
module data_mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  load_store_mem,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        wb_allowin,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [31:0] DMout_wb,
  output logic [2:0]  load_store_wb,
  output logic [1:0]  data_sram_addr_byte_wb,
  output logic        addr_err_wb
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  type_q;
  logic        wr_q;
  logic [31:0] rdata_q;
  logic        wb_valid_q;
  logic [31:0] dmout_q;
  logic [2:0]  ls_wb_q;
  logic [1:0]  byte_wb_q;
  logic        err_wb_q;

  logic        is_mem, is_half, is_word, misalign, start;
  logic        wb_load_mem, wb_load_imm;
  logic [3:0]  wstrb_fmt;
  logic [31:0] wdata_fmt;

  assign is_mem   = mem_rd | mem_wr;
  assign is_half  = (load_store_mem[2:1] == 2'b01);
  assign is_word  = load_store_mem[2];
  assign misalign = is_mem & ((is_half & mem_addr[0]) | (is_word & (mem_addr[1:0] != 2'b00)));
  assign start    = (state_q == S_IDLE) & mem_valid & is_mem & ~misalign;

  assign wb_load_mem = (state_q == S_DONE) & wb_allowin;
  assign wb_load_imm = (state_q == S_IDLE) & mem_valid & (~is_mem | misalign) & wb_allowin;

  // Store lanes are formatted at capture so the bus outputs come straight from flops.
  always_comb begin
    wstrb_fmt = 4'b0000;
    wdata_fmt = mem_wdata;
    case (load_store_mem)
      3'b000, 3'b001: begin
        wstrb_fmt = 4'b0001 << mem_addr[1:0];
        wdata_fmt = {4{mem_wdata[7:0]}};
      end
      3'b010, 3'b011: begin
        wstrb_fmt = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{mem_wdata[15:0]}};
      end
      default: wstrb_fmt = 4'b1111;
    endcase
    if (!mem_wr) wstrb_fmt = 4'b0000;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  if (data_sram_addr_ok) state_d = S_WAIT;
      S_WAIT: if (data_sram_data_ok) state_d = S_DONE;
      S_DONE: if (wb_allowin) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      type_q     <= 3'b000;
      wr_q       <= 1'b0;
      rdata_q    <= 32'h0;
      wb_valid_q <= 1'b0;
      dmout_q    <= 32'h0;
      ls_wb_q    <= 3'b000;
      byte_wb_q  <= 2'b00;
      err_wb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= mem_addr;
        wdata_q <= wdata_fmt;
        wstrb_q <= wstrb_fmt;
        type_q  <= load_store_mem;
        wr_q    <= mem_wr;
      end
      if ((state_q == S_WAIT) && data_sram_data_ok && !wr_q) rdata_q <= data_sram_rdata;
      if (wb_allowin) begin
        if (wb_load_mem) begin
          wb_valid_q <= 1'b1;
          if (!wr_q) dmout_q <= rdata_q;
          ls_wb_q    <= type_q;
          byte_wb_q  <= addr_q[1:0];
          err_wb_q   <= 1'b0;
        end else if (wb_load_imm) begin
          wb_valid_q <= 1'b1;
          ls_wb_q    <= load_store_mem;
          byte_wb_q  <= mem_addr[1:0];
          err_wb_q   <= misalign;
        end else begin
          wb_valid_q <= 1'b0;
        end
      end
    end
  end

  assign data_sram_req   = (state_q == S_REQ);
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = (type_q[2:1] == 2'b00) ? 2'd0 :
                           (type_q[2:1] == 2'b01) ? 2'd1 : 2'd2;
  assign data_sram_addr  = addr_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_wdata = wdata_q;

  assign mem_stall = (state_q == S_REQ) | (state_q == S_WAIT) |
                     ((state_q == S_DONE) & ~wb_allowin) | start;

  assign wb_valid               = wb_valid_q;
  assign DMout_wb               = dmout_q;
  assign load_store_wb          = ls_wb_q;
  assign data_sram_addr_byte_wb = byte_wb_q;
  assign addr_err_wb            = err_wb_q;

endmodule

// File: doc/data_mem_access_ctrl.md
DATA_MEM_ACCESS_CTRL -- requirements
Module: data_mem_access_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock) and rst input 1 (synchronous reset, active high).
REQ-002 The block SHALL provide the following MEM-stage inputs:
- mem_valid input 1: the MEM stage holds a valid instruction.
- mem_rd input 1: the instruction is a load.
- mem_wr input 1: the instruction is a store.
- load_store_mem input 3: access type. 000 lb/sb, 001 lbu, 010 lh/sh, 011 lhu, 100 lw/sw, 101-111 treated as word.
- mem_addr input 32: byte address.
- mem_wdata input 32: store data, right-aligned.
- wb_allowin input 1: the WB stage can accept this cycle.
REQ-003 The block SHALL provide the following SRAM-like bus ports:
- data_sram_req output 1: request.
- data_sram_wr output 1: 1 = write.
- data_sram_size output 2: 0 = byte, 1 = half, 2 = word.
- data_sram_addr output 32: request address.
- data_sram_wstrb output 4: byte write strobes.
- data_sram_wdata output 32: write data.
- data_sram_addr_ok input 1: address accepted.
- data_sram_data_ok input 1: transfer complete.
- data_sram_rdata input 32: read data.
REQ-004 The block SHALL provide the following stage-control and WB-stage outputs:
- mem_stall output 1: hold the MEM stage.
- wb_valid output 1: WB stage holds a valid instruction.
- DMout_wb output 32: raw read word.
- load_store_wb output 3: registered access type.
- data_sram_addr_byte_wb output 2: registered mem_addr[1:0].
- addr_err_wb output 1: misaligned-access flag.

Function
REQ-005 The FSM SHALL have four states: IDLE, REQ, WAIT and DONE.
REQ-006 In IDLE, an access SHALL start when mem_valid=1, (mem_rd|mem_wr)=1 and the address is aligned. On start the block SHALL register addr, wdata, type and rd/wr, and move to REQ.
REQ-007 Misalignment SHALL be defined as: half access with addr[0]=1, or word access with addr[1:0]!=00. A misaligned access SHALL issue no request and no stall, and SHALL be treated as a non-memory instruction with addr_err_wb=1.
REQ-008 data_sram_req SHALL be 1 only in REQ. REQ SHALL move to WAIT on the cycle addr_ok=1. All bus request outputs SHALL stay stable while req=1 and addr_ok=0.
REQ-009 In WAIT, on data_ok=1 the block SHALL latch data_sram_rdata into an internal buffer (loads only) and move to DONE.
REQ-010 data_ok SHALL be ignored in IDLE, REQ and DONE.
REQ-011 In DONE with wb_allowin=1, the block SHALL load the WB registers and return to IDLE. With wb_allowin=0 it SHALL remain in DONE with the buffer held.
REQ-012 mem_stall SHALL equal (state==REQ) | (state==WAIT) | (state==DONE & !wb_allowin) | (state==IDLE & start).
REQ-013 WB-register loads SHALL follow these rules:
- Any non-memory or misaligned instruction in IDLE with mem_valid=1 and wb_allowin=1 SHALL load the WB registers the next cycle with no stall.
- When wb_allowin=1 and nothing is loaded, wb_valid SHALL go to 0 next cycle.
- When wb_allowin=0, all WB registers SHALL hold.
REQ-014 WB register contents on load SHALL be:
- DMout_wb = buffered rdata for loads, unchanged for stores and non-memory instructions.
- load_store_wb = type.
- data_sram_addr_byte_wb = addr[1:0].
- addr_err_wb = misaligned flag.
- wb_valid = 1.
REQ-015 data_sram_size SHALL be 0 for type 000/001, 1 for 010/011, and 2 otherwise. data_sram_addr SHALL be the full byte address. data_sram_wr SHALL be the registered mem_wr.
REQ-016 Write strobes and data SHALL be:
- sb: wstrb = 0001<<addr[1:0], wdata = byte replicated x4.
- sh: wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1), wdata = half replicated x2.
- sw: wstrb = 1111, wdata as given.
- Loads: wstrb = 0000.
REQ-017 Minimum latency for an accepted access SHALL be:
- start at T0, req at T1 with addr_ok at T1;
- data_ok at T2;
- DONE at T3 with mem_stall=0 if wb_allowin=1;
- wb_valid=1 at T4.
REQ-018 If mem_rd and mem_wr are both 1, the access SHALL be treated as a store.

Reset
REQ-019 While rst=1 the block SHALL set: state=IDLE, data_sram_req=0, wstrb=0, mem_stall=0, wb_valid=0, DMout_wb=0, load_store_wb=000, data_sram_addr_byte_wb=00, addr_err_wb=0.
REQ-020 A reset in REQ, WAIT or DONE SHALL abandon the access. A data_ok arriving after reset SHALL be ignored, and no WB load SHALL occur.

Verification
REQ-021 lw at 0x100, with addr_ok in the first REQ cycle, data_ok one cycle later (rdata=0xDEADBEEF) and wb_allowin=1 SHALL give: req high 1 cycle, size=2, mem_stall high 3 cycles, then wb_valid=1 with DMout_wb=0xDEADBEEF, load_store_wb=100 and addr_byte_wb=00.
REQ-022 sb at 0x203 with wdata=0x000000A5 SHALL give: wstrb=1000, wdata=0xA5A5A5A5, size=0, wr=1. sh at 0x202 with wdata=0x1234 SHALL give: wstrb=1100, wdata=0x12341234.
REQ-023 lh at 0x301 SHALL give: no req, mem_stall=0, and on the next cycle wb_valid=1 with addr_err_wb=1. lw at 0x302 SHALL give the same result.
REQ-024 With addr_ok delayed 3 cycles and wb_allowin=0 for 2 cycles in DONE, req and addr/wstrb SHALL be held constant, mem_stall SHALL stay high until DONE with wb_allowin=1, and exactly one WB load SHALL occur.
REQ-025 With rst=1 asserted in WAIT and data_ok arriving the next cycle, the block SHALL stay in IDLE with wb_valid=0, DMout_wb=0 and no stall. A lbu issued afterwards SHALL complete normally.
